// File: rtl/md_io_regs.sv
// 68000-side I/O controller register file for the three MegaDrive pad ports.
// Holds version/data/control/serial registers and raises the TH falling-edge interrupt.
module md_io_regs #(
    parameter logic [3:0] VERSION  = 4'h0,
    parameter logic [6:0] EXT_IDLE = 7'h7F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EXPORT,
    input  logic       PAL,
    input  logic       NO_DISK,
    input  logic       sel,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [6:0] port1_out,
    input  logic [6:0] port2_out,
    output logic [6:0] port1_in,
    output logic [6:0] port1_dir,
    output logic [6:0] port2_in,
    output logic [6:0] port2_dir,
    output logic       th_irq
);

    logic [7:0] r_data  [0:2];
    logic [7:0] r_ctrl  [0:2];
    logic [7:0] r_tx    [0:2];
    logic [7:0] r_rx    [0:2];
    logic [7:0] r_sctrl [0:2];
    logic [2:0] r_th_prev;
    logic [7:0] r_dout;
    logic       r_th_irq;

    logic [6:0] w_pins [0:2];
    logic [7:0] w_version;
    logic [7:0] w_rdata;
    logic [2:0] w_th_edge;

    // Bits configured as outputs read back the latched data; inputs read the pin.
    function automatic logic [7:0] data_readback(input logic [7:0] data,
                                                 input logic [7:0] ctrl,
                                                 input logic [6:0] pins);
        data_readback = {data[7], (ctrl[6:0] & data[6:0]) | (~ctrl[6:0] & pins)};
    endfunction

    assign w_pins[0] = port1_out;
    assign w_pins[1] = port2_out;
    assign w_pins[2] = EXT_IDLE;
    assign w_version = {EXPORT, PAL, NO_DISK, 1'b0, VERSION};

    // Edge detect uses the CTRL value held before any same-cycle write.
    assign w_th_edge[0] = r_th_prev[0] & ~w_pins[0][6] & ~r_ctrl[0][6] & r_ctrl[0][7];
    assign w_th_edge[1] = r_th_prev[1] & ~w_pins[1][6] & ~r_ctrl[1][6] & r_ctrl[1][7];
    assign w_th_edge[2] = r_th_prev[2] & ~w_pins[2][6] & ~r_ctrl[2][6] & r_ctrl[2][7];

    // Read data multiplexer for the CPU register map.
    always_comb begin
        w_rdata = 8'h00;
        case (addr)
            4'h0:    w_rdata = w_version;
            4'h1:    w_rdata = data_readback(r_data[0], r_ctrl[0], w_pins[0]);
            4'h2:    w_rdata = data_readback(r_data[1], r_ctrl[1], w_pins[1]);
            4'h3:    w_rdata = data_readback(r_data[2], r_ctrl[2], w_pins[2]);
            4'h4:    w_rdata = r_ctrl[0];
            4'h5:    w_rdata = r_ctrl[1];
            4'h6:    w_rdata = r_ctrl[2];
            4'h7:    w_rdata = r_tx[0];
            4'h8:    w_rdata = r_rx[0];
            4'h9:    w_rdata = r_sctrl[0];
            4'hA:    w_rdata = r_tx[1];
            4'hB:    w_rdata = r_rx[1];
            4'hC:    w_rdata = r_sctrl[1];
            4'hD:    w_rdata = r_tx[2];
            4'hE:    w_rdata = r_rx[2];
            4'hF:    w_rdata = r_sctrl[2];
            default: w_rdata = 8'h00;
        endcase
    end

    // Register writes, registered read data, TH history and interrupt pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                r_data[i]  <= 8'h7F;
                r_ctrl[i]  <= 8'h00;
                r_tx[i]    <= 8'hFF;
                r_rx[i]    <= 8'h00;
                r_sctrl[i] <= 8'h00;
            end
            r_th_prev <= 3'b111;
            r_dout    <= 8'h00;
            r_th_irq  <= 1'b0;
        end else begin
            if (sel && we) begin
                case (addr)
                    4'h1:    r_data[0]  <= din;
                    4'h2:    r_data[1]  <= din;
                    4'h3:    r_data[2]  <= din;
                    4'h4:    r_ctrl[0]  <= din;
                    4'h5:    r_ctrl[1]  <= din;
                    4'h6:    r_ctrl[2]  <= din;
                    4'h7:    r_tx[0]    <= din;
                    4'h9:    r_sctrl[0] <= din;
                    4'hA:    r_tx[1]    <= din;
                    4'hC:    r_sctrl[1] <= din;
                    4'hD:    r_tx[2]    <= din;
                    4'hF:    r_sctrl[2] <= din;
                    default: ;
                endcase
            end
            if (sel && !we) begin
                r_dout <= w_rdata;
            end else begin
                r_dout <= r_dout;
            end
            r_th_prev <= {w_pins[2][6], w_pins[1][6], w_pins[0][6]};
            r_th_irq  <= |w_th_edge;
        end
    end

    assign dout      = r_dout;
    assign th_irq    = r_th_irq;
    assign port1_in  = r_data[0][6:0];
    assign port1_dir = r_ctrl[0][6:0];
    assign port2_in  = r_data[1][6:0];
    assign port2_dir = r_ctrl[1][6:0];

endmodule

// File: tb/tb_md_io_regs.sv
// Directed self-checking bench for md_io_regs: register map, readback mux,
// TH interrupt edge rules and reset behaviour.
module tb_md_io_regs;

    logic       clk;
    logic       reset;
    logic       EXPORT;
    logic       PAL;
    logic       NO_DISK;
    logic       sel;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [6:0] port1_out;
    logic [6:0] port2_out;
    logic [6:0] port1_in;
    logic [6:0] port1_dir;
    logic [6:0] port2_in;
    logic [6:0] port2_dir;
    logic       th_irq;

    int n_checks;
    int n_errors;
    logic [7:0] rd;

    md_io_regs #(.VERSION(4'h0), .EXT_IDLE(7'h7F)) dut (
        .clk(clk), .reset(reset), .EXPORT(EXPORT), .PAL(PAL), .NO_DISK(NO_DISK),
        .sel(sel), .we(we), .addr(addr), .din(din), .dout(dout),
        .port1_out(port1_out), .port2_out(port2_out),
        .port1_in(port1_in), .port1_dir(port1_dir),
        .port2_in(port2_in), .port2_dir(port2_dir), .th_irq(th_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        d = dout;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b1; EXPORT = 1'b1; PAL = 1'b0; NO_DISK = 1'b1;
        sel = 1'b0; we = 1'b0; addr = 4'h0; din = 8'h00;
        port1_out = 7'h7F; port2_out = 7'h7F;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check_val("rst_dout", dout, 8'h00);
        check_val("rst_irq", th_irq, 1'b0);
        check_val("rst_p1_in", port1_in, 7'h7F);
        check_val("rst_p1_dir", port1_dir, 7'h00);
        check_val("rst_p2_in", port2_in, 7'h7F);
        check_val("rst_p2_dir", port2_dir, 7'h00);
        read_reg(4'h1, rd); check_val("rst_data1", rd, 8'h7F);
        read_reg(4'h4, rd); check_val("rst_ctrl1", rd, 8'h00);
        read_reg(4'h7, rd); check_val("rst_tx1", rd, 8'hFF);
        read_reg(4'hE, rd); check_val("rst_rx3", rd, 8'h00);

        // dout holds while idle
        repeat (3) @(negedge clk);
        check_val("dout_hold", dout, 8'h00);

        // Output/input mix on port 1
        write_reg(4'h4, 8'h40);
        check_val("p1_dir", port1_dir, 7'h40);
        write_reg(4'h1, 8'h00);
        check_val("p1_in", port1_in, 7'h00);
        port1_out = 7'h3F;
        read_reg(4'h1, rd); check_val("data1_mix", rd, 8'h3F);
        write_reg(4'h1, 8'hC0);
        port1_out = 7'h05;
        read_reg(4'h1, rd); check_val("data1_mix2", rd, 8'hC5);
        check_val("p1_in2", port1_in, 7'h40);

        // TH interrupt on port 2
        write_reg(4'h5, 8'h80);
        check_val("p2_dir", port2_dir, 7'h00);
        port2_out = 7'h3F;
        @(negedge clk); check_val("irq_fall", th_irq, 1'b1);
        @(negedge clk); check_val("irq_one_cycle", th_irq, 1'b0);
        port2_out = 7'h7F;
        @(negedge clk); check_val("irq_rise0", th_irq, 1'b0);
        @(negedge clk); check_val("irq_rise1", th_irq, 1'b0);
        write_reg(4'h5, 8'hC0);
        port2_out = 7'h3F;
        @(negedge clk); check_val("irq_th_out", th_irq, 1'b0);
        @(negedge clk); check_val("irq_th_out2", th_irq, 1'b0);

        // Enabling while TH already low does not fire
        write_reg(4'h5, 8'h00);
        port2_out = 7'h7F;
        @(negedge clk);
        port2_out = 7'h3F;
        @(negedge clk); check_val("irq_disabled", th_irq, 1'b0);
        write_reg(4'h5, 8'h80);
        check_val("irq_enable_low0", th_irq, 1'b0);
        @(negedge clk); check_val("irq_enable_low1", th_irq, 1'b0);

        // CTRL write coincident with edge uses pre-write value
        port2_out = 7'h7F;
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = 4'h5; din = 8'h00; port2_out = 7'h3F;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
        check_val("irq_prewrite", th_irq, 1'b1);
        read_reg(4'h5, rd); check_val("ctrl2_after", rd, 8'h00);

        // Two ports edging together produce one pulse
        port1_out = 7'h7F; port2_out = 7'h7F;
        write_reg(4'h4, 8'h80);
        write_reg(4'h5, 8'h80);
        port1_out = 7'h3F; port2_out = 7'h3F;
        @(negedge clk); check_val("irq_both", th_irq, 1'b1);
        @(negedge clk); check_val("irq_both_end", th_irq, 1'b0);

        // Version register
        read_reg(4'h0, rd); check_val("version", rd, 8'hA0);
        write_reg(4'h0, 8'h55);
        read_reg(4'h0, rd); check_val("version_ro", rd, 8'hA0);
        PAL = 1'b1; EXPORT = 1'b0;
        read_reg(4'h0, rd); check_val("version2", rd, 8'h60);

        // Serial registers and EXT data
        write_reg(4'h8, 8'h12);
        read_reg(4'h8, rd); check_val("rx1_ro", rd, 8'h00);
        write_reg(4'hD, 8'h5A);
        read_reg(4'hD, rd); check_val("tx3", rd, 8'h5A);
        write_reg(4'hC, 8'h3C);
        read_reg(4'hC, rd); check_val("sctrl2", rd, 8'h3C);
        read_reg(4'h3, rd); check_val("data3", rd, 8'h7F);
        write_reg(4'h3, 8'h80);
        read_reg(4'h3, rd); check_val("data3_b7", rd, 8'hFF);

        // Reset mid-operation
        write_reg(4'h4, 8'hFF);
        write_reg(4'h1, 8'h00);
        check_val("pre_rst_dir", port1_dir, 7'h7F);
        check_val("pre_rst_in", port1_in, 7'h00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("mid_rst_dir", port1_dir, 7'h00);
        check_val("mid_rst_in", port1_in, 7'h7F);
        check_val("mid_rst_irq", th_irq, 1'b0);
        check_val("mid_rst_dout", dout, 8'h00);

        // Pending edge dropped by reset
        port1_out = 7'h7F;
        write_reg(4'h4, 8'h80);
        @(negedge clk);
        port1_out = 7'h3F; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_drop_irq", th_irq, 1'b0);
        @(negedge clk); check_val("rst_drop_irq2", th_irq, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/md_io_regs.md
Name: md_io_regs

Overview:
- 68000-side I/O controller register file for the three MegaDrive controller ports (port 1, port 2, EXT).
- Holds the version, data, control and serial registers.
- Drives the data and direction bits consumed by the pad/multitap input stage.
- Returns port pin levels to the CPU and raises the TH-edge (HL) interrupt request toward the VDP.

Parameters:
- VERSION, 4'h0, hardware version nibble returned in version register bits 3:0.
- EXT_IDLE, 7'h7F, pin levels seen on the EXT port (no device attached).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- EXPORT  in  1  overseas/domestic flag, version bit 7
- PAL  in  1  PAL/NTSC flag, version bit 6
- NO_DISK  in  1  1 = no expansion unit, version bit 5
- sel  in  1  CPU access strobe, one cycle per access
- we  in  1  1 = write, 0 = read (qualified by sel)
- addr  in  4  register index (CPU A[4:1])
- din  in  8  write data (low byte)
- dout  out  8  read data, registered
- port1_out  in  7  pin levels from input stage, port 1
- port2_out  in  7  pin levels from input stage, port 2
- port1_in  out  7  data-register bits 6:0 driven to port 1
- port1_dir  out  7  control-register bits 6:0 for port 1 (1 = output)
- port2_in  out  7  as port1_in, port 2
- port2_dir  out  7  as port1_dir, port 2
- th_irq  out  1  one-cycle HL interrupt request pulse

Behaviour:
- Register map (addr):
  - 0: version = {EXPORT, PAL, NO_DISK, 1'b0, VERSION}; read-only, writes ignored.
  - 1..3: DATA1..3.
  - 4..6: CTRL1..3.
  - 7/8/9: TxData1/RxData1/SCtrl1.
  - A/B/C: TxData2/RxData2/SCtrl2.
  - D/E/F: TxData3/RxData3/SCtrl3.
- Reset values:
  - DATA = 8'h7F; CTRL = 8'h00; TxData = 8'hFF; RxData = 8'h00; SCtrl = 8'h00.
  - dout = 8'h00; th_irq = 0; TH history = 1 for all ports.
  - Consequence: port1_in = port2_in = 7'h7F, port1_dir = port2_dir = 7'h00.
- Write (sel & we):
  - The addressed register takes din at the clock edge.
  - port*_in and port*_dir reflect the new value from the next cycle.
  - RxData is read-only; writes to it are ignored.
  - Serial registers are storage only; no serial transfer is modelled.
- Read (sel & ~we):
  - dout is registered one cycle after sel and holds until the next read.
  - DATAn read: bit 7 = DATAn[7].
  - DATAn read, bits 6:0, per bit i: CTRLn[i] ? DATAn[i] : pins_n[i].
  - pins_n = port1_out / port2_out / EXT_IDLE for n = 1 / 2 / 3.
  - All other registers read their stored value.
- TH interrupt:
  - Per port n, track TH = pins_n[6], registered each cycle.
  - Raise th_irq for exactly one cycle when all three hold:
    - previous TH = 1 and current TH = 0;
    - CTRLn[6] = 0 (TH is an input);
    - CTRLn[7] = 1 (interrupt enabled).
  - Multiple ports edging in the same cycle produce a single pulse.
  - The TH history register updates every cycle regardless of CTRL.
  - Enabling CTRLn[7] while TH is already low does not fire; only a new falling edge does.
- Simultaneous events:
  - A CTRL write in the same cycle as a TH edge uses the pre-write CTRL value.
  - A read of a register written in the same cycle returns the old value.
- Reset mid-operation: all registers return to reset values on the next edge; a pending th_irq is dropped.
- Invalid/idle: sel = 0 causes no register change; dout holds.

Test Plan:
- Reset, then read addr 1, 4, 7 -> dout 8'h7F, 8'h00, 8'hFF; port1_in = 7'h7F, port1_dir = 7'h00.
- Write CTRL1 = 8'h40, DATA1 = 8'h00, port1_out = 7'h3F -> port1_dir = 7'h40, port1_in = 7'h00; read DATA1 = 8'h3F.
- Write CTRL2 = 8'h80, toggle port2_out[6] 1->0 -> th_irq high exactly 1 cycle; 0->1 -> no pulse; repeat with CTRL2 = 8'hC0 -> no pulse.
- EXPORT = 1, PAL = 0, NO_DISK = 1, VERSION = 4'h0: read addr 0 -> 8'hA0; write 8'h55 to addr 0 and re-read -> 8'hA0.
- Write RxData1 = 8'h12 -> read 8'h00; write TxData3 = 8'h5A -> read 8'h5A; read DATA3 with CTRL3 = 0 -> 8'h7F.
- Assert reset while CTRL1 = 8'hFF, DATA1 = 8'h00 -> next cycle port1_dir = 7'h00, port1_in = 7'h7F, th_irq = 0.
